// File: rtl/console_pkg.sv
// Shared constants for the text console write path: grid defaults, control codes,
// arbiter states and cursor operation codes.
package console_pkg;

    localparam int          DEF_COLS      = 80;
    localparam int          DEF_ROWS      = 30;
    localparam logic [8:0]  DEF_BLANK_CHR = 9'h020;

    localparam logic [8:0]  CC_LF = 9'h00A;
    localparam logic [8:0]  CC_CR = 9'h00D;
    localparam logic [8:0]  CC_BS = 9'h008;
    localparam logic [8:0]  CC_FF = 9'h00C;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    localparam logic [2:0]  OP_NONE    = 3'd0;
    localparam logic [2:0]  OP_ADV     = 3'd1;
    localparam logic [2:0]  OP_NEWLINE = 3'd2;
    localparam logic [2:0]  OP_CR      = 3'd3;
    localparam logic [2:0]  OP_BS      = 3'd4;
    localparam logic [2:0]  OP_HOME    = 3'd5;

endpackage

// File: rtl/console_cursor.sv
// Stream cursor on a COLS x ROWS grid; x wraps into a y advance, y wraps to the top
// (no scrolling).
module console_cursor
    import console_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [2:0] op_i,
    output logic [6:0] x_o,
    output logic [5:0] y_o
);

    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [5:0] Y_LAST = 6'(ROWS - 1);

    logic [6:0] x_q, x_d;
    logic [5:0] y_q, y_d;
    logic [5:0] y_inc;

    assign y_inc = (y_q == Y_LAST) ? 6'd0 : y_q + 6'd1;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (op_i)
            OP_ADV: begin
                if (x_q == X_LAST) begin
                    x_d = 7'd0;
                    y_d = y_inc;
                end else begin
                    x_d = x_q + 7'd1;
                end
            end
            OP_NEWLINE: begin
                x_d = 7'd0;
                y_d = y_inc;
            end
            OP_CR: x_d = 7'd0;
            OP_BS: begin
                if (x_q != 7'd0) begin
                    x_d = x_q - 7'd1;
                end
            end
            OP_HOME: begin
                x_d = 7'd0;
                y_d = 6'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            x_q <= 7'd0;
            y_q <= 6'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/console_write_arbiter.sv
// Shares the console character write port between the core OUT stream and the debug
// overlay writer, interprets stream control codes and runs the full-screen clear.
module console_write_arbiter
    import console_pkg::*;
#(
    parameter int         COLS      = DEF_COLS,
    parameter int         ROWS      = DEF_ROWS,
    parameter logic [8:0] BLANK_CHR = DEF_BLANK_CHR
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       stream_valid,
    input  logic [8:0] stream_chr,
    output logic       stream_ready,
    input  logic       dbg_valid,
    input  logic [6:0] dbg_x,
    input  logic [5:0] dbg_y,
    input  logic [8:0] dbg_chr,
    output logic       dbg_ready,
    input  logic       clear_req,
    output logic       busy,
    output logic [6:0] cursor_x,
    output logic [5:0] cursor_y,
    output logic [6:0] char_x,
    output logic [5:0] char_y,
    output logic [8:0] char_chr,
    output logic       char_str
);

    localparam logic [11:0] CLR_LAST = 12'(COLS * ROWS - 1);
    localparam logic [6:0]  X_LAST   = 7'(COLS - 1);
    localparam logic [6:0]  COLS_W   = 7'(COLS);
    localparam logic [5:0]  ROWS_W   = 6'(ROWS);

    arb_state_e  state_q, state_d;
    logic        favor_dbg_q, favor_dbg_d;
    logic [11:0] clr_cnt_q, clr_cnt_d;
    logic [6:0]  clr_x_q, clr_x_d;
    logic [5:0]  clr_y_q, clr_y_d;
    logic [6:0]  char_x_q, char_x_d;
    logic [5:0]  char_y_q, char_y_d;
    logic [8:0]  char_chr_q, char_chr_d;
    logic        char_str_q, char_str_d;
    logic [2:0]  cur_op;
    logic        grant_stream;
    logic        grant_dbg;

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk_sys (clk_sys),
        .reset   (reset),
        .op_i    (cur_op),
        .x_o     (cursor_x),
        .y_o     (cursor_y)
    );

    always_comb begin
        state_d      = state_q;
        favor_dbg_d  = favor_dbg_q;
        clr_cnt_d    = clr_cnt_q;
        clr_x_d      = clr_x_q;
        clr_y_d      = clr_y_q;
        char_x_d     = char_x_q;
        char_y_d     = char_y_q;
        char_chr_d   = char_chr_q;
        char_str_d   = 1'b0;
        cur_op       = OP_NONE;
        stream_ready = 1'b0;
        dbg_ready    = 1'b0;
        // Round-robin: with both valid, the one not granted last time wins.
        grant_stream = stream_valid && (!dbg_valid || !favor_dbg_q);
        grant_dbg    = dbg_valid && !grant_stream;

        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else if (grant_stream) begin
                    stream_ready = 1'b1;
                    favor_dbg_d  = 1'b1;
                    case (stream_chr)
                        CC_LF: cur_op = OP_NEWLINE;
                        CC_CR: cur_op = OP_CR;
                        CC_FF: state_d = ST_CLEAR;
                        CC_BS: begin
                            if (cursor_x != 7'd0) begin
                                cur_op     = OP_BS;
                                char_x_d   = cursor_x - 7'd1;
                                char_y_d   = cursor_y;
                                char_chr_d = BLANK_CHR;
                                char_str_d = 1'b1;
                            end
                        end
                        default: begin
                            cur_op     = OP_ADV;
                            char_x_d   = cursor_x;
                            char_y_d   = cursor_y;
                            char_chr_d = stream_chr;
                            char_str_d = 1'b1;
                        end
                    endcase
                end else if (grant_dbg) begin
                    dbg_ready   = 1'b1;
                    favor_dbg_d = 1'b0;
                    // Off-grid debug writes complete the handshake but never reach the RAM.
                    if (dbg_x < COLS_W && dbg_y < ROWS_W) begin
                        char_x_d   = dbg_x;
                        char_y_d   = dbg_y;
                        char_chr_d = dbg_chr;
                        char_str_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                char_x_d   = clr_x_q;
                char_y_d   = clr_y_q;
                char_chr_d = BLANK_CHR;
                char_str_d = 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = 12'd0;
                    clr_x_d   = 7'd0;
                    clr_y_d   = 6'd0;
                    cur_op    = OP_HOME;
                end else begin
                    clr_cnt_d = clr_cnt_q + 12'd1;
                    if (clr_x_q == X_LAST) begin
                        clr_x_d = 7'd0;
                        clr_y_d = clr_y_q + 6'd1;
                    end else begin
                        clr_x_d = clr_x_q + 7'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            favor_dbg_q <= 1'b0;
            clr_cnt_q   <= 12'd0;
            clr_x_q     <= 7'd0;
            clr_y_q     <= 6'd0;
            char_x_q    <= 7'd0;
            char_y_q    <= 6'd0;
            char_chr_q  <= 9'd0;
            char_str_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            favor_dbg_q <= favor_dbg_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_x_q     <= clr_x_d;
            clr_y_q     <= clr_y_d;
            char_x_q    <= char_x_d;
            char_y_q    <= char_y_d;
            char_chr_q  <= char_chr_d;
            char_str_q  <= char_str_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign char_x   = char_x_q;
    assign char_y   = char_y_q;
    assign char_chr = char_chr_q;
    assign char_str = char_str_q;

endmodule

// File: tb/tb_console_write_arbiter.sv
// Directed bench for console_write_arbiter: stream codes, wrap, round-robin, clear
// timing and reset during clear.
module tb_console_write_arbiter;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       stream_valid;
    logic [8:0] stream_chr;
    logic       stream_ready;
    logic       dbg_valid;
    logic [6:0] dbg_x;
    logic [5:0] dbg_y;
    logic [8:0] dbg_chr;
    logic       dbg_ready;
    logic       clear_req;
    logic       busy;
    logic [6:0] cursor_x;
    logic [5:0] cursor_y;
    logic [6:0] char_x;
    logic [5:0] char_y;
    logic [8:0] char_chr;
    logic       char_str;

    int errors = 0;
    int checks = 0;

    always #4 clk_sys = ~clk_sys;

    console_write_arbiter dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .stream_valid (stream_valid),
        .stream_chr   (stream_chr),
        .stream_ready (stream_ready),
        .dbg_valid    (dbg_valid),
        .dbg_x        (dbg_x),
        .dbg_y        (dbg_y),
        .dbg_chr      (dbg_chr),
        .dbg_ready    (dbg_ready),
        .clear_req    (clear_req),
        .busy         (busy),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .char_x       (char_x),
        .char_y       (char_y),
        .char_chr     (char_chr),
        .char_str     (char_str)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        stream_valid = 1'b0;
        dbg_valid    = 1'b0;
        clear_req    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic stream_n(input int n, input logic [8:0] c);
        stream_valid = 1'b1;
        stream_chr   = c;
        repeat (n) tick();
        stream_valid = 1'b0;
    endtask

    task automatic put_cursor(input int n);
        do_reset();
        stream_n(n, 9'h041);
    endtask

    int n_str, first_cyc, last_cyc, e_addr, e_rdy, e_busy;

    initial begin
        reset = 1'b1; stream_valid = 1'b0; stream_chr = 9'd0;
        dbg_valid = 1'b0; dbg_x = 7'd0; dbg_y = 6'd0; dbg_chr = 9'd0; clear_req = 1'b0;
        repeat (3) tick();
        chk("rst_str", char_str, 0);
        chk("rst_charx", char_x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cursor", {cursor_x, cursor_y}, 0);
        reset = 1'b0;

        // "A","B" back to back
        stream_valid = 1'b1; stream_chr = 9'h041; #1;
        chk("ab_ready", stream_ready, 1);
        tick();
        chk("a_write", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd0, 6'd0, 9'h041});
        stream_chr = 9'h042;
        tick();
        chk("b_write", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd1, 6'd0, 9'h042});
        stream_valid = 1'b0;
        tick();
        chk("ab_idle_str", char_str, 0);
        chk("ab_cursor", {cursor_x, cursor_y}, {7'd2, 6'd0});

        // Line wrap and full-grid wrap
        put_cursor(80);
        stream_n(1, 9'h043);
        chk("wrap81", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd0, 6'd1, 9'h043});
        stream_n(2318, 9'h041);
        chk("pre_last_cursor", {cursor_x, cursor_y}, {7'd79, 6'd29});
        stream_n(1, 9'h044);
        chk("last_cell", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd79, 6'd29, 9'h044});
        chk("grid_wrap_cursor", {cursor_x, cursor_y}, 0);

        // Control codes at (5,3)
        put_cursor(245);
        stream_n(1, 9'h00A);
        chk("lf_str", char_str, 0);
        chk("lf_cursor", {cursor_x, cursor_y}, {7'd0, 6'd4});
        put_cursor(245);
        stream_n(1, 9'h008);
        chk("bs_write", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd4, 6'd3, 9'h020});
        chk("bs_cursor", {cursor_x, cursor_y}, {7'd4, 6'd3});
        stream_n(1, 9'h00D);
        chk("cr_str", char_str, 0);
        chk("cr_cursor", {cursor_x, cursor_y}, {7'd0, 6'd3});
        stream_n(1, 9'h008);
        chk("bs0_str", char_str, 0);
        chk("bs0_cursor", {cursor_x, cursor_y}, {7'd0, 6'd3});

        // Round-robin with both requesters held valid
        do_reset();
        stream_valid = 1'b1; stream_chr = 9'h050;
        dbg_valid = 1'b1; dbg_x = 7'd10; dbg_y = 6'd5; dbg_chr = 9'h1AA;
        #1;
        chk("rr0_ready", {stream_ready, dbg_ready}, 2'b10);
        tick();
        chk("rr0_write", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd0, 6'd0, 9'h050});
        chk("rr1_ready", {stream_ready, dbg_ready}, 2'b01);
        tick();
        chk("rr1_write", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd10, 6'd5, 9'h1AA});
        chk("rr2_ready", {stream_ready, dbg_ready}, 2'b10);
        tick();
        chk("rr2_write", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd1, 6'd0, 9'h050});
        chk("rr3_ready", {stream_ready, dbg_ready}, 2'b01);
        tick();
        chk("rr3_write", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd10, 6'd5, 9'h1AA});
        stream_valid = 1'b0; dbg_x = 7'd80; #1;
        chk("dbg_x80_ready", dbg_ready, 1);
        tick();
        chk("dbg_x80_str", char_str, 0);
        dbg_x = 7'd10; dbg_y = 6'd30;
        tick();
        chk("dbg_y30_str", char_str, 0);
        dbg_valid = 1'b0;

        // clear_req with an off-grid debug requester held valid to observe readies
        put_cursor(3);
        dbg_valid = 1'b1; dbg_x = 7'd80; dbg_y = 6'd0;
        clear_req = 1'b1;
        n_str = 0; first_cyc = -1; last_cyc = -1; e_addr = 0; e_rdy = 0; e_busy = 0;
        for (int t = 0; t < 2410; t++) begin
            if (t == 10) clear_req = 1'b1;
            #1;
            if (dbg_ready !== (t >= 2401)) e_rdy++;
            tick();
            clear_req = 1'b0;
            if (char_str) begin
                if (char_x != 7'(n_str % 80) || char_y != 6'(n_str / 80) || char_chr != 9'h020)
                    e_addr++;
                if (first_cyc < 0) first_cyc = t + 1;
                last_cyc = t + 1;
                n_str++;
            end
            if (busy !== (t + 1 <= 2400)) e_busy++;
        end
        dbg_valid = 1'b0;
        chk("clr_strobes", n_str, 2400);
        chk("clr_first", first_cyc, 2);
        chk("clr_last", last_cyc, 2401);
        chk("clr_addr_errs", e_addr, 0);
        chk("clr_ready_errs", e_rdy, 0);
        chk("clr_busy_errs", e_busy, 0);
        chk("clr_cursor", {cursor_x, cursor_y}, 0);

        // Form feed from the stream
        put_cursor(2);
        stream_valid = 1'b1; stream_chr = 9'h00C; #1;
        chk("ff_ready", stream_ready, 1);
        tick();
        stream_valid = 1'b0;
        chk("ff_busy_str", {busy, char_str}, 2'b10);
        repeat (2400) tick();
        chk("ff_done", {busy, cursor_x, cursor_y}, 0);

        // Reset at the 100th clear write
        do_reset();
        clear_req = 1'b1;
        n_str = 0;
        for (int t = 0; t < 200 && n_str < 100; t++) begin
            tick();
            clear_req = 1'b0;
            if (char_str) n_str++;
        end
        chk("mid_clr_count", n_str, 100);
        chk("mid_clr_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_outs", {char_str, char_x, char_y, char_chr, busy, cursor_x, cursor_y}, 0);
        reset = 1'b0;
        stream_valid = 1'b1; stream_chr = 9'h041; #1;
        chk("post_rst_ready", stream_ready, 1);
        tick();
        stream_valid = 1'b0;
        chk("post_rst_write", {char_str, char_x, char_y, char_chr}, {1'b1, 7'd0, 6'd0, 9'h041});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/console_write_arbiter.md
# console_write_arbiter

Owns the text console's single character write port (char_x/char_y/char_chr/char_str) and shares it between two requesters: the core's OUT character stream and the positioned debug overlay writer. It keeps the stream cursor on an 80x30 grid and interprets a small set of control codes. It also runs a full-screen clear sequence. It sits between flapjack_core/debug logic and the character display RAM writer.

## Interface
Parameters:
- COLS, 80, grid width; cursor x range 0..COLS-1
- ROWS, 30, grid height; cursor y range 0..ROWS-1
- BLANK_CHR, 9'h020, character written by clear and backspace

Ports:
- clk_sys  in  1  system clock (125 MHz)
- reset  in  1  reset reset, synchronous, active-high; clock clk_sys
- stream_valid  in  1  core stream character offered
- stream_chr  in  9  stream character or control code
- stream_ready  out  1  stream handshake accept
- dbg_valid  in  1  debug positioned write offered
- dbg_x  in  7  debug column
- dbg_y  in  6  debug row
- dbg_chr  in  9  debug character
- dbg_ready  out  1  debug handshake accept
- clear_req  in  1  single-cycle clear request
- busy  out  1  clear sequence in progress
- cursor_x  out  7  current stream column
- cursor_y  out  6  current stream row
- char_x  out  7  write column to display
- char_y  out  6  write row to display
- char_chr  out  9  write character
- char_str  out  1  write strobe, one cycle per write

## Operation
- States: IDLE, CLEAR.
- In IDLE, a clear_req or a stream form feed (9'h00C) enters CLEAR. clear_req takes priority over both requesters, so neither handshake completes that cycle.
- Handshake occurs when valid && ready. Valid must not depend on ready. Ready is combinational from state, clear_req and both valids.
- Arbitration in IDLE is round-robin. If only one requester is valid, it is granted. If both are valid, the requester not granted last time is granted. The pointer updates only on a completed handshake.
- Stream codes, matched on the full 9 bits:
  - 9'h00A: x=0, y advances.
  - 9'h00D: x=0.
  - 9'h008: if x>0, x decrements and BLANK_CHR is written at the new x; at x=0, nothing happens.
  - 9'h00C: clear.
  - Any other code is written at (x,y), then x advances.
  - Control codes other than backspace produce no strobe.
- x advance: at x=COLS-1, x wraps to 0 and y advances. y advance: at y=ROWS-1, y wraps to 0. There is no scrolling.
- Debug writes go to (dbg_x, dbg_y) and do not touch the cursor. A write with dbg_x>=COLS or dbg_y>=ROWS is accepted and dropped, with no strobe.
- CLEAR writes BLANK_CHR in raster order, (0,0) through (COLS-1,ROWS-1), one write per cycle. It then sets the cursor to (0,0) and returns to IDLE. clear_req and form feed arriving during CLEAR are ignored. Both readies are low in CLEAR.
- Reset, including during CLEAR, aborts immediately:
  - char_x, char_y, char_chr, char_str = 0
  - cursor = (0,0)
  - busy = 0
  - state = IDLE
  - round-robin favours stream
  - the clear counter is cleared

## Timing
- All outputs are registered. A handshake in cycle N produces char_* with char_str high in cycle N+1, for exactly one cycle.
- Back-to-back handshakes are allowed every cycle.
- Cursor outputs update in N+1.
- clear_req sampled in IDLE at cycle N:
  - busy is high for N+1 .. N+COLS*ROWS.
  - char_str is high for N+2 .. N+COLS*ROWS+1 (2400 strobes at the defaults).
  - State is IDLE at N+COLS*ROWS+1, where a handshake may occur.
- Form feed handshake at N follows the same timing as clear_req at N.
- The clear counter is 12 bits (0..COLS*ROWS-1). Cursor arithmetic is performed at the port widths.

## Structure
- Package console_pkg holds:
  - COLS/ROWS defaults and BLANK_CHR
  - control code constants CC_LF, CC_CR, CC_BS, CC_FF
  - state enum typedef
- Sub-module console_cursor holds the cursor registers and the advance/newline/CR/backspace/home operations with wrap. It is instantiated once.

## Test plan
- Stream "A","B" (9'h041, 9'h042) from reset -> strobes at (0,0)=041 then (1,0)=042 on consecutive cycles; cursor=(2,0).
- Stream 80 chars then 9'h043 -> 81st write at (0,1). Cursor at (79,29) plus one char -> cursor (0,0).
- Stream 9'h00A at cursor (5,3) -> no strobe, cursor (0,4). 9'h008 at (5,3) -> strobe (4,3)=020, cursor (4,3). 9'h008 at (0,3) -> no change.
- stream_valid and dbg_valid held high for 4 cycles -> grants alternate stream, dbg, stream, dbg. dbg_x=80 -> accepted, no strobe.
- clear_req pulse at N -> 2400 blank strobes N+2..N+2401, readies low N..N+2400, cursor (0,0) afterwards; second clear_req at N+10 is ignored.
- reset asserted at the 100th clear write -> next cycle all outputs 0 and state IDLE; a stream char after reset is written at (0,0).
